// File: rtl/sha256_padder.sv
// Streaming SHA-256 pre-processor: packs 32-bit big-endian words into 512-bit blocks,
// appends FIPS 180-4 padding and the bit length, and hands each block to the core.
module sha256_padder (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    input  logic         s_last_i,
    input  logic [2:0]   s_bytes_i,
    output logic [511:0] core_block_o,
    output logic         core_init_o,
    output logic         core_next_o,
    input  logic         core_ready_i,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {StFill, StPad, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [15:0][31:0] blk_q, blk_d;
    logic [4:0]        widx_q, widx_d;
    logic [63:0]       len_q, len_d;
    logic              first_q, first_d;
    logic              mark_pend_q, mark_pend_d;
    logic              final_q, final_d;
    logic              ended_q, ended_d;
    logic              len_hi_q, len_hi_d;
    logic              init_q, init_d;
    logic              next_q, next_d;
    logic              done_raw;
    logic [3:0]        slot;
    logic [31:0]       tail_word;
    logic              wait_first;

    // Word 0 sits in the top 32 bits, so slot index is the inverted word index.
    assign slot       = ~widx_q[3:0];
    assign wait_first = init_q | next_q;

    always_comb begin
        tail_word = s_data_i;
        case (s_bytes_i)
            3'd0:    tail_word = 32'h8000_0000;
            3'd1:    tail_word = {s_data_i[31:24], 24'h80_0000};
            3'd2:    tail_word = {s_data_i[31:16], 16'h8000};
            3'd3:    tail_word = {s_data_i[31:8], 8'h80};
            default: tail_word = s_data_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        widx_d      = widx_q;
        len_d       = len_q;
        first_d     = first_q;
        mark_pend_d = mark_pend_q;
        final_d     = final_q;
        ended_d     = ended_q;
        len_hi_d    = len_hi_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        done_raw    = 1'b0;

        case (state_q)
            StFill: begin
                if (s_valid_i) begin
                    len_d  = len_q + {58'd0, s_bytes_i, 3'd0};
                    widx_d = widx_q + 5'd1;
                    if (s_last_i) begin
                        ended_d = 1'b1;
                        state_d = StPad;
                        if (s_bytes_i < 3'd4) begin
                            blk_d[slot] = tail_word;
                            mark_pend_d = 1'b0;
                        end else begin
                            blk_d[slot] = s_data_i;
                            mark_pend_d = 1'b1;
                        end
                    end else begin
                        blk_d[slot] = s_data_i;
                        if (widx_q == 5'd15) begin
                            state_d = StIssue;
                            final_d = 1'b0;
                        end
                    end
                end
            end
            StPad: begin
                if (widx_q[4]) begin
                    state_d = StIssue;
                    final_d = 1'b0;
                end else if (mark_pend_q) begin
                    blk_d[slot] = 32'h8000_0000;
                    mark_pend_d = 1'b0;
                    widx_d      = widx_q + 5'd1;
                end else if (widx_q <= 5'd13) begin
                    blk_d[slot] = 32'h0;
                    widx_d      = widx_q + 5'd1;
                end else if (widx_q == 5'd14) begin
                    blk_d[slot] = len_q[63:32];
                    len_hi_d    = 1'b1;
                    widx_d      = widx_q + 5'd1;
                end else if (len_hi_q) begin
                    blk_d[slot] = len_q[31:0];
                    len_hi_d    = 1'b0;
                    widx_d      = widx_q + 5'd1;
                    state_d     = StIssue;
                    final_d     = 1'b1;
                end else begin
                    // Marker landed in slot 14: length goes into a following block.
                    blk_d[slot] = 32'h0;
                    widx_d      = widx_q + 5'd1;
                    state_d     = StIssue;
                    final_d     = 1'b0;
                end
            end
            StIssue: begin
                if (core_ready_i) begin
                    init_d  = first_q;
                    next_d  = ~first_q;
                    first_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // The core still reports ready during the pulse cycle itself.
                if (!wait_first && core_ready_i) begin
                    widx_d = 5'd0;
                    if (final_q) begin
                        done_raw = 1'b1;
                        first_d  = 1'b1;
                        len_d    = 64'd0;
                        ended_d  = 1'b0;
                        state_d  = StFill;
                    end else begin
                        state_d = ended_q ? StPad : StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFill;
            blk_q       <= '0;
            widx_q      <= 5'd0;
            len_q       <= 64'd0;
            first_q     <= 1'b1;
            mark_pend_q <= 1'b0;
            final_q     <= 1'b0;
            ended_q     <= 1'b0;
            len_hi_q    <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            widx_q      <= widx_d;
            len_q       <= len_d;
            first_q     <= first_d;
            mark_pend_q <= mark_pend_d;
            final_q     <= final_d;
            ended_q     <= ended_d;
            len_hi_q    <= len_hi_d;
            init_q      <= init_d;
            next_q      <= next_d;
        end
    end

    // Pulses are suppressed while reset is held so nothing reaches the core mid-reset.
    assign core_init_o  = init_q & ~rst_i;
    assign core_next_o  = next_q & ~rst_i;
    assign done_o       = done_raw & ~rst_i;
    assign s_ready_o    = (state_q == StFill);
    assign busy_o       = (state_q != StFill);
    assign core_block_o = blk_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder with a behavioural stand-in for the sha256 core's
// ready/init/next handshake.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic [511:0] core_block;
    logic         core_init;
    logic         core_next;
    logic         core_ready;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_bytes_i   (s_bytes),
        .core_block_o(core_block),
        .core_init_o (core_init),
        .core_next_o (core_next),
        .core_ready_i(core_ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct {
        logic [511:0] blk;
        logic         is_init;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_done = 0;
    int   done_seen = 0;
    int   pulse_seen = 0;
    int   pulse_age = 1000;
    logic prev_pulse = 1'b0;

    // Core model: ready drops the cycle after init/next and returns after a fixed latency.
    logic hold = 1'b0;
    logic model_ready = 1'b1;
    int   model_cnt = 0;

    always @(posedge clk) begin
        if (core_init || core_next) begin
            model_ready <= 1'b0;
            model_cnt   <= 8;
        end else if (!model_ready) begin
            if (model_cnt == 0) model_ready <= 1'b1;
            else model_cnt <= model_cnt - 1;
        end
    end

    assign core_ready = model_ready & ~hold;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] dw(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4};
    endfunction

    function automatic logic [511:0] pack(input logic [31:0] w [16]);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32 * i -: 32] = w[i];
        return r;
    endfunction

    task automatic push_blk(input logic [31:0] w [16], input logic is_init);
        exp_t e;
        e.blk     = pack(w);
        e.is_init = is_init;
        exp_q.push_back(e);
    endtask

    // Monitor: every init/next pulse is matched against the next expected block.
    always @(negedge clk) begin
        exp_t e;
        if (core_init || core_next) begin
            check("pulse_exclusive", 512'(core_init & core_next), 512'(0));
            check("pulse_spacing", 512'(prev_pulse), 512'(0));
            pulse_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got block %0h want no pulse", core_block);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_init", 512'(core_init), 512'(e.is_init));
                check("block", core_block, e.blk);
            end
            pulse_age = 0;
        end else if (pulse_age < 1000) begin
            pulse_age++;
        end
        prev_pulse = core_init || core_next;
        if (done) begin
            check("done_expected", 512'(exp_done > 0), 512'(1));
            if (exp_done > 0) exp_done--;
            check("done_after_blocks", 512'(exp_q.size()), 512'(0));
            check("done_after_core", 512'(pulse_age >= 5), 512'(1));
            done_seen++;
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb,
                             input int gap);
        logic accepted;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        s_bytes  = nb;
        accepted = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            accepted = s_ready;
            @(posedge clk);
            #1;
        end
        check("beat_accepted", 512'(accepted), 512'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = 3'd4;
    endtask

    task automatic wait_done();
        int n;
        n = done_seen;
        for (int t = 0; t < 300 && done_seen == n; t++) @(posedge clk);
        check("done_seen", 512'(done_seen != n), 512'(1));
        #1;
    endtask

    task automatic wait_pulse();
        int n;
        n = pulse_seen;
        for (int t = 0; t < 300 && pulse_seen == n; t++) @(posedge clk);
        check("pulse_seen", 512'(pulse_seen != n), 512'(1));
        #1;
    endtask

    // Assert reset for one edge, then check the cycle after shows reset outputs.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_no_pulse_in_rst"}, 512'({core_init, core_next, done}), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, 512'(s_ready), 512'(1));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_block"}, core_block, 512'(0));
        check({tag, "_pulses"}, 512'({core_init, core_next, done}), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic abc_expect(input logic with_done);
        logic [31:0] w [16];
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        w[0]  = 32'h6162_6380;
        w[15] = 32'h0000_0018;
        push_blk(w, 1'b1);
        if (with_done) exp_done++;
    endtask

    initial begin
        logic [31:0] w [16];
        logic [31:0] w2 [16];
        logic [31:0] t13;
        int          bad;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;
        s_bytes = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 512'(s_ready), 512'(1));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_block", core_block, 512'(0));
        check("rst_pulses", 512'({core_init, core_next, done}), 512'(0));
        @(posedge clk);
        #1;

        // "abc"; low byte of the beat is junk and must be dropped.
        abc_expect(1'b1);
        send_beat(32'h6162_63FF, 1'b1, 3'd3, 0);
        wait_done();

        // Empty message.
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        w[0] = 32'h8000_0000;
        push_blk(w, 1'b1);
        exp_done++;
        send_beat(32'hDEAD_BEEF, 1'b1, 3'd0, 0);
        wait_done();

        // 56 bytes: marker fills slot 14, length spills into a second block.
        for (int i = 0; i < 14; i++) w[i] = dw(i);
        w[14] = 32'h8000_0000;
        w[15] = 32'h0;
        push_blk(w, 1'b1);
        for (int i = 0; i < 16; i++) w2[i] = 32'h0;
        w2[15] = 32'h0000_01C0;
        push_blk(w2, 1'b0);
        exp_done++;
        for (int i = 0; i < 14; i++) send_beat(dw(i), i == 13, 3'd4, 0);
        wait_done();

        // 55 bytes: single block, marker inside word 13.
        t13 = dw(13);
        for (int i = 0; i < 13; i++) w[i] = dw(i);
        w[13] = {t13[31:8], 8'h80};
        w[14] = 32'h0;
        w[15] = 32'h0000_01B8;
        push_blk(w, 1'b1);
        exp_done++;
        for (int i = 0; i < 13; i++) send_beat(dw(i), 1'b0, 3'd4, 0);
        send_beat({t13[31:8], 8'hEE}, 1'b1, 3'd3, 0);
        wait_done();

        // 64 bytes with random gaps on s_valid.
        for (int i = 0; i < 16; i++) w[i] = dw(i);
        push_blk(w, 1'b1);
        for (int i = 0; i < 16; i++) w2[i] = 32'h0;
        w2[0]  = 32'h8000_0000;
        w2[15] = 32'h0000_0200;
        push_blk(w2, 1'b0);
        exp_done++;
        for (int i = 0; i < 16; i++) send_beat(dw(i), i == 15, 3'd4, $urandom_range(0, 2));
        wait_done();

        // Core stalled well past the point the block reaches ISSUE.
        hold = 1'b1;
        abc_expect(1'b1);
        send_beat(32'h6162_6300, 1'b1, 3'd3, 0);
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (core_init || core_next || s_ready) bad++;
            @(posedge clk);
        end
        check("stall_quiet", 512'(bad), 512'(0));
        #1;
        hold = 1'b0;
        @(negedge clk);
        check("stall_no_pulse_on_rise", 512'(core_init), 512'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_pulse_after_rise", 512'(core_init), 512'(1));
        @(posedge clk);
        #1;
        wait_done();

        // Reset while padding: nothing may be issued.
        send_beat(32'h6162_6300, 1'b1, 3'd3, 0);
        @(negedge clk);
        check("pad_busy", 512'(busy), 512'(1));
        @(posedge clk);
        #1;
        pulse_reset("rst_pad");

        // Reset while waiting on the core: the block went out but no done follows.
        abc_expect(1'b0);
        send_beat(32'h6162_6300, 1'b1, 3'd3, 0);
        wait_pulse();
        pulse_reset("rst_wait");

        // Fresh "abc" after reset must start with init.
        abc_expect(1'b1);
        send_beat(32'h6162_6300, 1'b1, 3'd3, 0);
        wait_done();

        repeat (30) @(posedge clk);
        check("leftover_blocks", 512'(exp_q.size()), 512'(0));
        check("leftover_done", 512'(exp_done), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
